// File: rtl/add_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and
// default operand / slice widths.
package add_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Chunk index counter width; a single-chunk build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit slice adder used once per clock by add_seq.
module add_chunk
    import add_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/add_seq.sv
// Sequential add/subtract that processes CHUNK bits per clock, finishing
// a WIDTH-bit operation in WIDTH/CHUNK RUN cycles.
module add_seq
    import add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bop_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] full_sum;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             c_out;
    logic             accept;
    logic             last;

    assign a_slice = a_reg[int'(idx)*CHUNK +: CHUNK];
    assign b_slice = bop_reg[int'(idx)*CHUNK +: CHUNK];

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .sum  (s_slice),
        .cout (c_out)
    );

    // Partial sum with this cycle's slice merged in; on the last chunk it is the result.
    always_comb begin
        full_sum = sum_reg;
        full_sum[int'(idx)*CHUNK +: CHUNK] = s_slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + ~cin, so cout=0 signals a borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            bop_reg <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            out     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg   <= a;
                bop_reg <= sub ? ~b : b;
                carry   <= sub ? ~cin : cin;
                idx     <= '0;
            end else if (busy) begin
                sum_reg <= full_sum;
                carry   <= c_out;
                idx     <= last ? '0 : idx + IDX_W'(1);
                if (last) begin
                    out  <= full_sum;
                    cout <= c_out;
                    ovf  <= (a_reg[WIDTH-1] == bop_reg[WIDTH-1]) &&
                            (full_sum[WIDTH-1] != a_reg[WIDTH-1]);
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: 32/8, 16/4 and 8/8 builds side by side,
// checked cycle by cycle against a reference model and result scoreboard.
module tb_add_seq;

    typedef struct {
        logic [31:0] out;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] out;
        logic        cout;
        logic        ovf;
    } dir_t;

    int w_tab [3] = '{32, 16, 8};
    int n_tab [3] = '{4, 4, 1};

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0]       start_v;
    logic [2:0]       sub_v;
    logic [2:0]       cin_v;
    logic [2:0][31:0] a_v;
    logic [2:0][31:0] b_v;

    logic [31:0] out0;
    logic [15:0] out1;
    logic [7:0]  out2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;
    logic cout0, cout1, cout2;
    logic ovf0, ovf1, ovf2;

    logic [2:0][31:0] out_v;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0]       cout_v;
    logic [2:0]       ovf_v;

    assign out_v  = {{24'd0, out2}, {16'd0, out1}, out0};
    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};
    assign cout_v = {cout2, cout1, cout0};
    assign ovf_v  = {ovf2, ovf1, ovf0};

    int n_compared   = 0;
    int n_mismatched = 0;

    int          cnt [3];
    logic [2:0]  exp_done;
    exp_t        hold [3];
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];

    always #5 clk = ~clk;

    add_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
        .busy(busy0), .done(done0), .out(out0), .cout(cout0), .ovf(ovf0)
    );

    add_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin_v[1]),
        .busy(busy1), .done(done1), .out(out1), .cout(cout1), .ovf(ovf1)
    );

    add_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
        .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]),
        .busy(busy2), .done(done2), .out(out2), .cout(cout2), .ovf(ovf2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic st, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic c);
        start_v[k] = st;
        sub_v[k]   = s;
        a_v[k]     = a;
        b_v[k]     = b;
        cin_v[k]   = c;
    endtask

    // Reference arithmetic done on integers: overflow is a signed result out of range.
    function automatic exp_t ref_op(input int w, input logic s, input logic [31:0] a,
                                    input logic [31:0] b, input logic c);
        longint mask, half, ua, ub, sa, sb, ci, u, r;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        ci   = c ? 1 : 0;
        sa   = (ua >= half) ? ua - (half << 1) : ua;
        sb   = (ub >= half) ? ub - (half << 1) : ub;
        if (!s) begin
            u      = ua + ub + ci;
            e.cout = (u >= (half << 1));
            r      = sa + sb + ci;
        end else begin
            u      = ua - ub - ci;
            e.cout = (ua >= ub + ci);
            r      = sa - sb - ci;
        end
        e.out = 32'(u & mask);
        e.ovf = (r >= half) || (r < -half);
        return e;
    endfunction

    function automatic void sb_push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_pop(input int k, output exp_t e, output bit ok);
        ok = (sb_size(k) > 0);
        e  = '{32'd0, 1'b0, 1'b0};
        if (ok) begin
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    function automatic logic [31:0] pick_operand(input int w);
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'd0;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Cycle model: accept when idle, N RUN edges, done in the following cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                cnt[k]      = 0;
                exp_done[k] = 1'b0;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_done[k] = 1'b0;
                if (cnt[k] > 0) begin
                    cnt[k]--;
                    if (cnt[k] == 0) exp_done[k] = 1'b1;
                end else if (start_v[k]) begin
                    sb_push(k, ref_op(w_tab[k], sub_v[k], a_v[k], b_v[k], cin_v[k]));
                    cnt[k] = n_tab[k];
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) hold[k] = '{32'd0, 1'b0, 1'b0};
            checkOutput($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(cnt[k] != 0));
            checkOutput($sformatf("done%0d", k), 32'(done_v[k]), 32'(exp_done[k]));
            if (done_v[k]) begin
                sb_pop(k, e, ok);
                checkOutput($sformatf("sb_avail%0d", k), 32'(ok), 32'd1);
                if (ok) hold[k] = e;
            end
            checkOutput($sformatf("out%0d", k),  out_v[k],         hold[k].out);
            checkOutput($sformatf("cout%0d", k), 32'(cout_v[k]),   32'(hold[k].cout));
            checkOutput($sformatf("ovf%0d", k),  32'(ovf_v[k]),    32'(hold[k].ovf));
        end
    end

    task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        @(negedge clk);
        applyStimulus(0, 1'b1, s, a, b, c);
        @(negedge clk);
        applyStimulus(0, 1'b0, s, a, b, c);
        repeat (n_tab[0] + 1) @(negedge clk);
    endtask

    task automatic checkDirected(input string tag, input logic [31:0] o,
                                 input logic co, input logic ov);
        checkOutput({tag, "_out"},  out0,       o);
        checkOutput({tag, "_cout"}, 32'(cout0), 32'(co));
        checkOutput({tag, "_ovf"},  32'(ovf0),  32'(ov));
    endtask

    dir_t dir_tab [7] = '{
        '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0},
        '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
        '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0},
        '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1},
        '{1'b1, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0006, 1'b1, 1'b0},
        '{1'b0, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0, 1'b0}
    };

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy0), 32'd0);
        checkOutput("reset_out",  out0,       32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            runOp(dir_tab[i].sub, dir_tab[i].a, dir_tab[i].b, dir_tab[i].cin);
            checkDirected($sformatf("dir%0d", i), dir_tab[i].out, dir_tab[i].cout,
                          dir_tab[i].ovf);
        end

        // A second start while busy must be dropped without affecting the first result.
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (n_tab[0] + 2) @(negedge clk);
        checkDirected("ignore", 32'h2345_6789, 1'b0, 1'b0);

        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy0), 32'd0);
        checkOutput("midrst_done", 32'(done0), 32'd0);
        checkOutput("midrst_out",  out0,       32'd0);
        checkOutput("midrst_cout", 32'(cout0), 32'd0);
        checkOutput("midrst_ovf",  32'(ovf0),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runOp(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        checkDirected("postrst", 32'h0000_0030, 1'b0, 1'b0);

        // Held start with fresh operands every cycle: back-to-back accepts.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            applyStimulus(0, 1'b1, 1'($urandom_range(0, 1)), pick_operand(32),
                          pick_operand(32), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (n_tab[0] + 2) @(negedge clk);

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                applyStimulus(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              pick_operand(w_tab[k]), pick_operand(w_tab[k]),
                              1'($urandom_range(0, 1)));
            end
        end
        for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("sb_left%0d", k), 32'(sb_size(k)), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
